// File: rtl/mac_pkg.sv
// Shared defaults, FSM state encoding and beat-count width for the MAC accumulator.
package mac_pkg;

  localparam int MAC_WIDTH = 16;
  localparam int MAC_ACC_W = 40;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational ACC_W-bit signed adder; with MAC_SAT_EN defined it clamps on overflow
// and raises ovf, otherwise it wraps in two's complement and ovf stays 0.
module mac_sat_add #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  assign raw = a + b;

`ifdef MAC_SAT_EN
  logic ovf_raw;

  // Overflow only when both operands share a sign that the raw result lost.
  assign ovf_raw = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    sum = raw;
    ovf = ovf_raw;
    if (ovf_raw) begin
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums signed product beats into a dot-product group; result valid 1 cycle after the last
// beat and held until out_ready, in_ready low meanwhile. Saturation enabled by MAC_SAT_EN.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH,
  parameter int ACC_W = MAC_ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_prod,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_sat
);

  mac_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             sat_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_sat_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] acc_d;
  logic             ovf;
  logic [CNT_W-1:0] count_d;
  logic             sat_d;
  logic             accept;

  assign prod_ext = {{(ACC_W-2*WIDTH){in_prod[2*WIDTH-1]}}, in_prod};
  assign accept   = in_valid && (state_q != HOLD);

  // A beat arriving in IDLE starts a new group, so it is added to zero.
  assign add_a = (state_q == IDLE) ? '0 : acc_q;

  mac_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a   (add_a),
    .b   (prod_ext),
    .sum (acc_d),
    .ovf (ovf)
  );

  always_comb begin
    count_d = count_q;
    if (state_q == IDLE) begin
      count_d = CNT_W'(1);
    end else if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end
    sat_d = sat_q | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            if (in_last) begin
              out_data_q  <= acc_d;
              out_count_q <= count_d;
              out_sat_q   <= sat_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

`ifdef MAC_SAT_EN
  assign out_sat = out_sat_q;
`else
  logic unused_sat;
  assign unused_sat = out_sat_q;
  assign out_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: a default-size instance and an ACC_W=33 instance share all inputs.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_sat;
  logic [39:0] out_data;
  logic [7:0]  out_count;

  logic        d33_in_ready, d33_out_valid, d33_out_sat;
  logic [32:0] d33_out_data;
  logic [7:0]  d33_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  mac_accumulator #(
    .WIDTH (16),
    .ACC_W (33)
  ) dut33 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (d33_in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (d33_out_valid),
    .out_ready (out_ready),
    .out_data  (d33_out_data),
    .out_count (d33_out_count),
    .out_sat   (d33_out_sat)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one beat for exactly one clock edge, then return 1 time unit after it.
  task automatic beat(input logic [31:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  $signed(out_data), 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_sat",   out_sat,   0);

    // 6 + (-4) + 10, back-to-back with out_ready held high
    beat(32'd6, 1'b0);
    beat(-32'sd4, 1'b0);
    check("grp1_valid_before_last", out_valid, 0);
    beat(32'd10, 1'b1);
    check("grp1_valid_latency", out_valid, 1);
    check("grp1_data",  $signed(out_data), 12);
    check("grp1_count", out_count, 3);
    check("grp1_sat",   out_sat, 0);
    tick();
    check("grp1_valid_one_cycle", out_valid, 0);
    check("grp1_in_ready_back",   in_ready, 1);

    // single negative beat, sign-extended to 40 bits
    beat(-32'sd1073741824, 1'b1);
    check("neg_valid", out_valid, 1);
    check("neg_data",  $signed(out_data), -64'sd1073741824);
    check("neg_count", out_count, 1);
    tick();

    // backpressure: result held while out_ready=0, extra beats refused
    out_ready = 1'b0;
    beat(32'd3, 1'b1);
    in_valid = 1'b1;
    in_prod  = 32'd100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_in_ready", in_ready, 0);
      check("hold_valid",    out_valid, 1);
      check("hold_data",     $signed(out_data), 3);
      check("hold_count",    out_count, 1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_valid",    out_valid, 0);
    check("release_in_ready", in_ready, 1);
    beat(32'd2, 1'b0);
    beat(32'd5, 1'b1);
    check("fresh_data",  $signed(out_data), 7);
    check("fresh_count", out_count, 2);
    tick();

    // reset mid-group drops the partial sum
    beat(32'd7, 1'b0);
    beat(32'd8, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid",    out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_data",     $signed(out_data), 0);
    beat(32'd5, 1'b1);
    check("midrst_new_data",  $signed(out_data), 5);
    check("midrst_new_count", out_count, 1);
    tick();

    // 300 beats: count saturates at 255 while the sum keeps going
    for (int i = 0; i < 299; i++) beat(32'd1, 1'b0);
    beat(32'd1, 1'b1);
    check("cnt_sat_count", out_count, 255);
    check("cnt_sat_data",  $signed(out_data), 300);
    tick();

    // 5 x 2^30 overflows the 33-bit accumulator
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'd1073741824, 1'b0);
    beat(32'd1073741824, 1'b1);
    check("ovf_valid33", d33_out_valid, 1);
    check("ovf_count33", d33_out_count, 5);
`ifdef MAC_SAT_EN
    check("ovf_data33", $signed(d33_out_data), 64'sd4294967295);
    check("ovf_sat33",  d33_out_sat, 1);
`else
    check("ovf_data33", $signed(d33_out_data), -64'sd4294967296 + 64'sd1073741824);
    check("ovf_sat33",  d33_out_sat, 0);
`endif
    check("ovf_data40", $signed(out_data), 64'sd5368709120);
    check("ovf_sat40",  out_sat, 0);
    tick();
    check("ovf_clear33", d33_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
